pong_game_ctrl: RTL
===================

// Module: pong_game_ctrl
// PURPOSE
//  Game-flow sequencer for the two-player pong display datapath. Drives gra_still to hold and recentre the ball.
//  Consumes the datapath's hit/miss flags, keeps both scores, counts rallies, and runs serve delay and game over.
//  Sits between the button debouncers and the display block; scores feed the seven-segment driver.
// PARAMETERS
//  SCORE_W       4    score register width
//  WIN_SCORE     7    points to win; must be >=1 and <= 2**SCORE_W-1
//  SERVE_FRAMES  60   frame ticks the ball is held before each serve; must be >=1
//  CNT_W         8    serve frame counter width; 2**CNT_W > SERVE_FRAMES
// PORTS
//  clock       in   1        system clock; the only clock
//  reset       in   1        synchronous, active-high
//  start       in   1        debounced start button, level
//  frame_tick  in   1        1-cycle pulse per frame (x==0,y==481)
//  hit         in   1        ball overlapping right paddle, level
//  miss        in   1        ball at right wall, level -> point to player 1
//  miss2       in   1        ball at left wall, level -> point to player 2
//  gra_still   out  1        1 = ball held at centre
//  score_1     out  SCORE_W  player 1 score
//  score_2     out  SCORE_W  player 2 score
//  rally       out  8        paddle hits in current point
//  point_1     out  1        1-cycle pulse: player 1 scored
//  point_2     out  1        1-cycle pulse: player 2 scored
//  game_over   out  1        1 while in OVER
//  winner      out  1        0 = player 1, 1 = player 2; valid while game_over
// BEHAVIOUR
//  - Single clock. Reset is synchronous and active-high. Every output is registered.
//  - Reset values: state=IDLE, gra_still=1, scores=0, rally=0, point_1/point_2=0, game_over=0, winner=0, frame_cnt=0.
//  - Reset outranks every other input. Asserting it mid-point or mid-serve returns to IDLE on the next edge.
//  - start_rise = start & ~start_q; start_q is registered, reset to 0. A held button gives exactly one rise.
//  - hit_rise is formed the same way from hit. hit_q is reset to 0.
//  - FSM is Moore. gra_still = (state != PLAY), registered, so it changes in the same cycle as state.
//  - IDLE: on start_rise -> SERVE; scores, rally and frame_cnt are cleared.
//  - SERVE: frame_cnt counts frame_tick. Entry always loads frame_cnt=0.
//      On frame_tick with frame_cnt==SERVE_FRAMES-1 -> PLAY; rally is cleared.
//      hit/miss/miss2 are ignored.
//  - PLAY: evaluated every cycle, not only on frame_tick.
//      miss & ~miss2: score_1+1 and point_1=1 for 1 cycle.
//        If the new score_1==WIN_SCORE -> OVER with winner=0; else -> SERVE.
//      miss2 & ~miss: score_2+1 and point_2=1 for 1 cycle.
//        If the new score_2==WIN_SCORE -> OVER with winner=1; else -> SERVE.
//      miss & miss2 together: void point. No score, no pulse -> SERVE.
//      Otherwise, hit_rise: rally+1, saturating at 8'hFF.
//      hit_rise in the same cycle as a miss is dropped; the miss wins.
//  - OVER: scores and winner are frozen, game_over=1. On start_rise -> SERVE with scores cleared.
//  - Latency: miss in PLAY at edge n -> at edge n+1: score updated, pulse high, state changed, gra_still=1.
//  - Misses are acted on only in PLAY. Level flags still high after leaving PLAY (ball not yet recentred) never double-score.
//  - Scores can never exceed WIN_SCORE, so they cannot wrap. Illegal state encodings recover to IDLE.
//  - start_rise in SERVE or PLAY has no effect.
// TESTING
//  1 reset, start pulse, 60 frame_ticks -> gra_still falls exactly after tick 60; scores 0, rally 0.
//  2 PLAY, 3 separate hit pulses, then miss held 5 cycles -> rally=3, score_1=1, one point_1 pulse, SERVE.
//  3 PLAY, miss and miss2 in same cycle -> scores unchanged, no pulses, SERVE, rally cleared after the serve.
//  4 score_2=6, miss2 -> score_2=7, point_2 pulse, game_over=1, winner=1; start held 10 cycles -> one restart.
//  5 reset asserted mid-SERVE (frame_cnt=30) with start held -> IDLE, all outputs at reset values.
//  6 300 hit pulses in one point -> rally saturates at 255; start pulses during PLAY ignored.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Game-flow sequencer for the two-player pong datapath: serve delay, scoring,
// rally counting and game-over handling. All outputs are registered.
module pong_game_ctrl #(
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int CNT_W        = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               hit,
  input  logic               miss,
  input  logic               miss2,
  output logic               gra_still,
  output logic [SCORE_W-1:0] score_1,
  output logic [SCORE_W-1:0] score_2,
  output logic [7:0]         rally,
  output logic               point_1,
  output logic               point_2,
  output logic               game_over,
  output logic               winner
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] PLAY  = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;

  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   LAST_FRAME = CNT_W'(SERVE_FRAMES - 1);

  logic [1:0]         state, state_n;
  logic               start_q, hit_q;
  logic               start_rise, hit_rise;
  logic [CNT_W-1:0]   frame_cnt, frame_cnt_n;
  logic [SCORE_W-1:0] score_1_n, score_2_n;
  logic [7:0]         rally_n;
  logic               point_1_n, point_2_n, winner_n;

  assign start_rise = start & ~start_q;
  assign hit_rise   = hit & ~hit_q;

  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    score_1_n   = score_1;
    score_2_n   = score_2;
    rally_n     = rally;
    point_1_n   = 1'b0;
    point_2_n   = 1'b0;
    winner_n    = winner;
    case (state)
      IDLE: begin
        if (start_rise) begin
          state_n     = SERVE;
          score_1_n   = '0;
          score_2_n   = '0;
          rally_n     = '0;
          frame_cnt_n = '0;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (frame_cnt == LAST_FRAME) begin
            state_n     = PLAY;
            rally_n     = '0;
            frame_cnt_n = '0;
          end else begin
            frame_cnt_n = frame_cnt + 1'b1;
          end
        end
      end
      PLAY: begin
        // A miss on either wall outranks a simultaneous paddle hit.
        if (miss && !miss2) begin
          score_1_n   = score_1 + 1'b1;
          point_1_n   = 1'b1;
          frame_cnt_n = '0;
          if (score_1_n == WIN_VAL) begin
            state_n  = OVER;
            winner_n = 1'b0;
          end else begin
            state_n = SERVE;
          end
        end else if (miss2 && !miss) begin
          score_2_n   = score_2 + 1'b1;
          point_2_n   = 1'b1;
          frame_cnt_n = '0;
          if (score_2_n == WIN_VAL) begin
            state_n  = OVER;
            winner_n = 1'b1;
          end else begin
            state_n = SERVE;
          end
        end else if (miss && miss2) begin
          state_n     = SERVE;
          frame_cnt_n = '0;
        end else if (hit_rise && rally != 8'hFF) begin
          rally_n = rally + 8'd1;
        end
      end
      OVER: begin
        if (start_rise) begin
          state_n     = SERVE;
          score_1_n   = '0;
          score_2_n   = '0;
          frame_cnt_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are derived from next-state so they change on the same edge as state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      hit_q     <= 1'b0;
      frame_cnt <= '0;
      score_1   <= '0;
      score_2   <= '0;
      rally     <= '0;
      point_1   <= 1'b0;
      point_2   <= 1'b0;
      winner    <= 1'b0;
      game_over <= 1'b0;
      gra_still <= 1'b1;
    end else begin
      state     <= state_n;
      start_q   <= start;
      hit_q     <= hit;
      frame_cnt <= frame_cnt_n;
      score_1   <= score_1_n;
      score_2   <= score_2_n;
      rally     <= rally_n;
      point_1   <= point_1_n;
      point_2   <= point_2_n;
      winner    <= winner_n;
      game_over <= (state_n == OVER);
      gra_still <= (state_n != PLAY);
    end
  end

endmodule
